// File: rtl/serial_add_ctrl_if.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl_if
//
// Request/result bundle for serial_add_ctrl.
//
// Handshake: the requester raises start with a/b valid. The adder accepts the
// request on the first rising edge where start=1 while it is idle or done
// (busy=0). Operands are captured on that edge only and may change freely
// afterwards. start seen while busy=1 is dropped, never queued. done is a
// single-cycle pulse; sum/carry are valid from that cycle and hold until the
// completing edge of the next accepted request.
//
// Signals:
//   start      requester -> adder   begin an addition
//   a, b       requester -> adder   WIDTH-bit operands
//   busy       adder -> requester   addition in progress
//   done       adder -> requester   one-cycle completion pulse
//   sum        adder -> requester   WIDTH-bit result of last completed add
//   carry      adder -> requester   carry-out of last completed add
//   state_dbg  adder -> observer    raw FSM state (0=IDLE, 1=RUN, 2=DONE)
// -----------------------------------------------------------------------------
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic [1:0]       state_dbg;

    modport master (
        output start, a, b,
        input  busy, done, sum, carry, state_dbg
    );

    modport slave (
        input  start, a, b,
        output busy, done, sum, carry, state_dbg
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
//
// Bit-serial adder sequencer. Two half_adr_str cells form one full-adder
// slice; the operands are shifted through it LSB first, one bit per clock,
// with a registered carry. After WIDTH steps the sum and carry-out are loaded
// into the result registers and done pulses for one cycle.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset, wins over start on the same edge
//   bus   serial_add_ctrl_if slave: start/a/b in, busy/done/sum/carry and
//         state_dbg out
//
// Also contains half_adr_str, the single-bit half adder cell.
// -----------------------------------------------------------------------------

// Single-bit half adder: s = a xor b, c = a and b.
module half_adr_str (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    serial_add_ctrl_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] sa, sb, sr, sr_next;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             cy;
    logic [CW-1:0]    cnt;

    logic s1, c1, s, c2, cy_next;
    logic accept, last_step;

    // Full-adder slice built from two half adders.
    half_adr_str u_ha1 (.a(sa[0]), .b(sb[0]), .s(s1), .c(c1));
    half_adr_str u_ha2 (.a(s1),    .b(cy),    .s(s),  .c(c2));

    assign cy_next = c1 | c2;

    // Result bits enter at the MSB and move right, so after WIDTH steps the
    // first computed bit sits at sr[0].
    generate
        if (WIDTH == 1) begin : g_sr_w1
            assign sr_next = s;
        end else begin : g_sr_wn
            assign sr_next = {s, sr[WIDTH-1:1]};
        end
    endgenerate

    assign last_step = (state == RUN) && (cnt == LAST);

    // Next-state logic
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (cnt == LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // Back-to-back request is taken here exactly as from IDLE.
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sa      <= '0;
            sb      <= '0;
            sr      <= '0;
            cy      <= 1'b0;
            cnt     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else if (accept) begin
            sa  <= bus.a;
            sb  <= bus.b;
            cy  <= 1'b0;
            cnt <= '0;
        end else if (state == RUN) begin
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            sr  <= sr_next;
            cy  <= cy_next;
            cnt <= cnt + 1'b1;
            // The result registers see the bit computed on this same edge.
            if (last_step) begin
                sum_q   <= sr_next;
                carry_q <= cy_next;
            end
        end
    end

    assign bus.busy      = (state == RUN);
    assign bus.done      = (state == DONE);
    assign bus.sum       = sum_q;
    assign bus.carry     = carry_q;
    assign bus.state_dbg = state;
endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial adder sequencer built around the team's `half_adr_str` cell. Two `half_adr_str` instances form one full-adder slice. The controller latches two WIDTH-bit operands on a start request and steps them through the slice one bit per clock, LSB first, with a registered carry. It presents the WIDTH-bit sum and carry-out with a one-cycle done pulse. The block is the reusable way to get multi-bit addition out of the single-bit half adder without replicating it WIDTH times.

## Interface

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 1 to 32.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset; sampled on rising clk edge.
- start  input  1  request to begin an addition; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A; captured on the accepting edge only.
- b  input  WIDTH  operand B; captured on the accepting edge only.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; high while in DONE.
- sum  output  WIDTH  registered result of the last completed addition.
- carry  output  1  registered carry-out of the last completed addition.

## Operation

- FSM states: IDLE, RUN, DONE. Encoding is free. busy = (state==RUN), done = (state==DONE), both decoded from state.
- IDLE:
  - start=1 → capture a into shift register sa and b into sb.
  - Clear the carry flop cy and bit counter cnt to 0.
  - Go to RUN.
  - start=0 → stay in IDLE.
- RUN, each edge:
  - Slice inputs are sa[0], sb[0], cy.
  - Half adder 1: (sa[0], sb[0]) → s1, c1.
  - Half adder 2: (s1, cy) → s, c2.
  - Update cy ← c1 | c2.
  - Shift s into the MSB of result register sr (right shift), so after WIDTH shifts sr[0] holds bit 0.
  - Shift sa and sb right by one.
  - cnt ← cnt+1.
  - When cnt == WIDTH-1 on this edge:
    - Load sum ← final sr value, including the bit computed on this edge.
    - Load carry ← final carry (c1|c2 of this edge).
    - Go to DONE.
- DONE:
  - start=1 → accept exactly as in IDLE (back-to-back operation) and go to RUN.
  - start=0 → go to IDLE.
- start in RUN is ignored; no queuing.
- a and b may change freely after the accepting edge with no effect on the result.
- sum/carry change only on the completing edge. During RUN they hold the previous result.
- cnt width is clog2(WIDTH)+1 bits; it never wraps within an operation.
- WIDTH=1: RUN lasts exactly one edge.

## Timing

- Reset values: state=IDLE, busy=0, done=0, sum=0, carry=0; sa, sb, sr, cy and cnt = 0.
- rst has priority over everything, including start on the same edge. Reset mid-RUN abandons the operation, zeroes sum/carry, and produces no done pulse.
- If start is accepted at edge E:
  - busy=1 after E through edge E+WIDTH.
  - sum/carry valid and done=1 after edge E+WIDTH, for exactly one cycle.
  - busy=0 in DONE.
- Latency: WIDTH cycles from accepting edge to done. Initiation interval is WIDTH+1 cycles with start held or re-asserted in DONE.
- sum/carry remain stable from the done cycle until the completing edge of the next operation.

## Test plan

- After reset, WIDTH=8: start with a=8'h00, b=8'h00 → done pulses 8 cycles later; sum=8'h00, carry=0; busy high for exactly 8 cycles.
- a=8'hFF, b=8'h01 → sum=8'h00, carry=1. Then a=8'hA5, b=8'h5A → sum=8'hFF, carry=0. Then a=8'hFF, b=8'hFF → sum=8'hFE, carry=1.
- Start a=8'h12, b=8'h34. Three cycles later assert start with a=8'hFF, b=8'hFF and change a/b every cycle → result sum=8'h46, carry=0; second request ignored; exactly one done pulse.
- Hold start=1 continuously with fixed a=8'h80, b=8'h80 → done pulses every 9 cycles; sum=8'h00, carry=1 each time; busy low only in DONE cycles.
- Start a=8'h0F, b=8'h01. Assert rst for one cycle at cycle 4 with start=1 on the same edge → busy=0, sum=0, carry=0, state IDLE, no done pulse; next start computes a fresh result (8'h10, carry 0).
- Set WIDTH=1 and sweep a/b over 00, 01, 10, 11 → done one cycle after each accept; (sum, carry) = (0,0), (1,0), (1,0), (0,1).
